// File: rtl/cpu_host_pkg.sv
// Shared definitions for the host-side controller of the A-RISC cpu.
// Holds the command codes, the response bytes, the controller state encoding
// and a decode helper that says which states accept an input byte.
package cpu_host_pkg;

    // Command codes (first byte of every frame)
    localparam logic [7:0] C_LDI = 8'h01;
    localparam logic [7:0] C_LDD = 8'h02;
    localparam logic [7:0] C_RUN = 8'h03;
    localparam logic [7:0] C_DMP = 8'h04;

    // Response bytes
    localparam logic [7:0] R_OK      = 8'hAA;
    localparam logic [7:0] R_BADCMD  = 8'hEE;
    localparam logic [7:0] R_TIMEOUT = 8'hEF;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_CMD,
        S_BASE,
        S_LEN,
        S_ILO,
        S_IHI,
        S_DWR,
        S_RUNW,
        S_START,
        S_BUSY,
        S_DONE,
        S_RDA,
        S_RDD,
        S_TX,
        S_RESP
    } state_e;

    // States in which the controller takes bytes from the input stream.
    function automatic logic accepts_input(state_e s);
        return s inside {S_CMD, S_BASE, S_LEN, S_ILO, S_IHI, S_DWR};
    endfunction

endpackage

// File: rtl/cpu_host_ctrl_if.sv
// Byte-stream link between a host transport (e.g. UART RX/TX) and the
// controller.
//   s_valid/s_data/s_ready : bytes travelling into the controller
//   m_valid/m_data/m_ready : bytes travelling out of the controller
// A byte moves when valid && ready on the rising clock edge.
// master = transport side, slave = controller side.
interface cpu_host_ctrl_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data
    );

endinterface

// File: rtl/host_tx_slot.sv
// One-entry output holding register with valid/ready on both sides.
//   clk, rstn    : clock, asynchronous active-low reset
//   push_valid_i : producer offers push_data_i
//   push_data_i  : byte to send
//   push_ready_o : slot takes the byte on this edge
//   m_valid_o    : a byte is held for the sink
//   m_data_o     : held byte, stable until m_ready_i
//   m_ready_i    : sink accepts m_data_o
module host_tx_slot (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push_valid_i,
    input  logic [7:0] push_data_i,
    output logic       push_ready_o,
    output logic       m_valid_o,
    output logic [7:0] m_data_o,
    input  logic       m_ready_i
);

    logic       valid_d, valid_q;
    logic [7:0] data_d, data_q;

    // A new byte may enter while the held one leaves on the same edge.
    assign push_ready_o = !valid_q || m_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
        end
        if (push_valid_i && push_ready_o) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
        end
    end

    register #(.W(1), .RESET(1'b0)) u_valid (.clk(clk), .rstn(rstn), .d(valid_d), .q(valid_q));
    register #(.W(8), .RESET(8'h00)) u_data (.clk(clk), .rstn(rstn), .d(data_d), .q(data_q));

    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;

endmodule

// File: rtl/register.sv
// Generic D flip-flop bank with asynchronous active-low reset.
//   clk  : clock
//   rstn : asynchronous reset, active low, loads RESET
//   d    : next value
//   q    : registered value
module register #(
    parameter int unsigned W         = 1,
    parameter logic [W-1:0] RESET    = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= RESET;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host-side controller for the A-RISC cpu memory/control interface.
// Decodes CMD/BASE/LEN/payload frames from a byte stream: loads IRAM words,
// loads DRAM bytes, starts the cpu and waits for it, or dumps DRAM back out.
//   clk, rstn            : clock, asynchronous active-low reset
//   host                 : byte streams in (s_*) and out (m_*)
//   iram_we/waddr/wdata  : IRAM write port (one-cycle strobe)
//   dram_we/addr/wdata   : DRAM port, dram_addr shared by reads and writes
//   dram_rdata           : DRAM read byte, valid one cycle after dram_addr
//   cpu_start            : one-cycle start pulse
//   cpu_idle             : cpu idle flag
//   host_owns            : 1 while the host owns the RAM ports
module cpu_host_ctrl
    import cpu_host_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rstn,
    cpu_host_ctrl_if.slave    host,
    output logic              iram_we,
    output logic [ADDR_W-1:0] iram_waddr,
    output logic [15:0]       iram_wdata,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [7:0]        dram_wdata,
    input  logic [7:0]        dram_rdata,
    output logic              cpu_start,
    input  logic              cpu_idle,
    output logic              host_owns
);

    // Item counter is one bit wider than the address so LEN=0 (2**ADDR_W) fits.
    localparam int unsigned CW = ADDR_W + 1;

    state_e              state_d, state_q;
    logic [STATE_W-1:0]  state_raw_q;
    logic [7:0]          cmd_d, cmd_q;
    logic [ADDR_W-1:0]   base_d, base_q;
    logic [CW-1:0]       len_d, len_q;
    logic [CW-1:0]       cnt_d, cnt_q;
    logic [7:0]          lo_d, lo_q;
    logic [7:0]          rd_d, rd_q;
    logic [7:0]          resp_d, resp_q;
    logic [31:0]         tmo_d, tmo_q;
    logic                iram_we_d;
    logic [ADDR_W-1:0]   iram_waddr_d;
    logic [15:0]         iram_wdata_d;
    logic                dram_we_d;
    logic [ADDR_W-1:0]   dram_addr_d;
    logic [7:0]          dram_wdata_d;
    logic                cpu_start_d;
    logic                host_owns_d;

    logic                s_fire;
    logic                push_valid, push_ready;
    logic [7:0]          push_data;
    logic [CW-1:0]       cnt_inc;
    logic [ADDR_W-1:0]   item_addr;
    logic                last_item;

    assign state_q      = state_e'(state_raw_q);
    assign host.s_ready = accepts_input(state_q);
    assign s_fire       = host.s_valid && host.s_ready;
    assign cnt_inc      = cnt_q + 1'b1;
    assign item_addr    = base_q + cnt_q[ADDR_W-1:0];
    assign last_item    = (cnt_inc == len_q);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        rd_d         = rd_q;
        resp_d       = resp_q;
        tmo_d        = tmo_q;
        iram_we_d    = 1'b0;
        iram_waddr_d = iram_waddr;
        iram_wdata_d = iram_wdata;
        dram_we_d    = 1'b0;
        dram_addr_d  = dram_addr;
        dram_wdata_d = dram_wdata;
        cpu_start_d  = 1'b0;
        host_owns_d  = host_owns;
        push_valid   = 1'b0;
        push_data    = resp_q;

        unique case (state_q)
            S_CMD: begin
                if (s_fire) begin
                    cmd_d   = host.s_data;
                    state_d = S_BASE;
                end
            end
            S_BASE: begin
                if (s_fire) begin
                    base_d  = ADDR_W'(host.s_data);
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (s_fire) begin
                    len_d = (host.s_data == 8'h00) ? (CW'(1) << ADDR_W) : CW'(host.s_data);
                    cnt_d = '0;
                    case (cmd_q)
                        C_LDI:   state_d = S_ILO;
                        C_LDD:   state_d = S_DWR;
                        C_RUN:   state_d = S_RUNW;
                        C_DMP: begin
                            dram_addr_d = base_q;
                            state_d     = S_RDA;
                        end
                        default: begin
                            resp_d  = R_BADCMD;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_ILO: begin
                if (s_fire) begin
                    lo_d    = host.s_data;
                    state_d = S_IHI;
                end
            end
            S_IHI: begin
                if (s_fire) begin
                    iram_we_d    = 1'b1;
                    iram_waddr_d = item_addr;
                    iram_wdata_d = {host.s_data, lo_q};
                    cnt_d        = cnt_inc;
                    if (last_item) begin
                        resp_d  = R_OK;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ILO;
                    end
                end
            end
            S_DWR: begin
                if (s_fire) begin
                    dram_we_d    = 1'b1;
                    dram_addr_d  = item_addr;
                    dram_wdata_d = host.s_data;
                    cnt_d        = cnt_inc;
                    if (last_item) begin
                        resp_d  = R_OK;
                        state_d = S_RESP;
                    end
                end
            end
            S_RUNW: begin
                if (cpu_idle) begin
                    host_owns_d = 1'b0;
                    cpu_start_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_START;
                end
            end
            S_START, S_BUSY, S_DONE: begin
                // Timeout counts cycles since the start pulse; a normal finish
                // on the same cycle takes precedence.
                tmo_d = tmo_q + 32'd1;
                if (state_q == S_START) begin
                    state_d = S_BUSY;
                end else if (state_q == S_BUSY) begin
                    if (!cpu_idle) begin
                        state_d = S_DONE;
                    end
                end else if (cpu_idle) begin
                    host_owns_d = 1'b1;
                    resp_d      = R_OK;
                    state_d     = S_RESP;
                end
                if ((TIMEOUT != 0) && (tmo_d == TIMEOUT) && (state_d != S_RESP)) begin
                    host_owns_d = 1'b1;
                    resp_d      = R_TIMEOUT;
                    state_d     = S_RESP;
                end
            end
            S_RDA: begin
                // dram_addr is stable this cycle; the RAM answers next cycle.
                state_d = S_RDD;
            end
            S_RDD: begin
                rd_d    = dram_rdata;
                state_d = S_TX;
            end
            S_TX: begin
                push_valid = 1'b1;
                push_data  = rd_q;
                if (push_ready) begin
                    cnt_d = cnt_inc;
                    if (last_item) begin
                        resp_d  = R_OK;
                        state_d = S_RESP;
                    end else begin
                        dram_addr_d = base_q + cnt_inc[ADDR_W-1:0];
                        state_d     = S_RDA;
                    end
                end
            end
            S_RESP: begin
                push_valid = 1'b1;
                push_data  = resp_q;
                if (push_ready) begin
                    state_d = S_CMD;
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    register #(.W(STATE_W), .RESET(STATE_W'(S_CMD))) u_state (
        .clk(clk), .rstn(rstn), .d(state_d), .q(state_raw_q));
    register #(.W(8)) u_cmd (.clk(clk), .rstn(rstn), .d(cmd_d), .q(cmd_q));
    register #(.W(ADDR_W)) u_base (.clk(clk), .rstn(rstn), .d(base_d), .q(base_q));
    register #(.W(CW)) u_len (.clk(clk), .rstn(rstn), .d(len_d), .q(len_q));
    register #(.W(CW)) u_cnt (.clk(clk), .rstn(rstn), .d(cnt_d), .q(cnt_q));
    register #(.W(8)) u_lo (.clk(clk), .rstn(rstn), .d(lo_d), .q(lo_q));
    register #(.W(8)) u_rd (.clk(clk), .rstn(rstn), .d(rd_d), .q(rd_q));
    register #(.W(8)) u_resp (.clk(clk), .rstn(rstn), .d(resp_d), .q(resp_q));
    register #(.W(32)) u_tmo (.clk(clk), .rstn(rstn), .d(tmo_d), .q(tmo_q));
    register #(.W(1)) u_iram_we (.clk(clk), .rstn(rstn), .d(iram_we_d), .q(iram_we));
    register #(.W(ADDR_W)) u_iram_waddr (
        .clk(clk), .rstn(rstn), .d(iram_waddr_d), .q(iram_waddr));
    register #(.W(16)) u_iram_wdata (
        .clk(clk), .rstn(rstn), .d(iram_wdata_d), .q(iram_wdata));
    register #(.W(1)) u_dram_we (.clk(clk), .rstn(rstn), .d(dram_we_d), .q(dram_we));
    register #(.W(ADDR_W)) u_dram_addr (
        .clk(clk), .rstn(rstn), .d(dram_addr_d), .q(dram_addr));
    register #(.W(8)) u_dram_wdata (
        .clk(clk), .rstn(rstn), .d(dram_wdata_d), .q(dram_wdata));
    register #(.W(1)) u_cpu_start (.clk(clk), .rstn(rstn), .d(cpu_start_d), .q(cpu_start));
    register #(.W(1), .RESET(1'b1)) u_host_owns (
        .clk(clk), .rstn(rstn), .d(host_owns_d), .q(host_owns));

    host_tx_slot u_tx_slot (
        .clk          (clk),
        .rstn         (rstn),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .push_ready_o (push_ready),
        .m_valid_o    (host.m_valid),
        .m_data_o     (host.m_data),
        .m_ready_i    (host.m_ready)
    );

endmodule
